data_mem_controller: RTL and testbench
======================================

Name: data_mem_controller

Overview:
- Shared load/store front end between the per-thread LDR/STR execution of compute_core and a single external data memory port.
- Accepts one request per thread, picks one with round-robin arbitration, and runs it on the memory side through a valid/ready handshake.
- Returns read data or a write acknowledge to the requesting thread.
- Exactly one memory transaction is in flight at a time; other threads stall on req_ready.

Parameters:
NUM_THREADS, 4, number of requesting threads (power of two, >=2)
THREAD_ID_WIDTH, 2, log2(NUM_THREADS)
ADDR_WIDTH, 8, data memory address width
DATA_WIDTH, 16, data word width

Ports:
clk  input  1  single clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
req_valid  input  NUM_THREADS  per-thread request pending
req_write  input  NUM_THREADS  1=STR, 0=LDR, per thread
req_addr  input  NUM_THREADS*ADDR_WIDTH  flattened addresses, thread t at [t*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  input  NUM_THREADS*DATA_WIDTH  flattened store data
req_ready  output  NUM_THREADS  one-hot, 1-cycle pulse: request accepted
resp_valid  output  NUM_THREADS  one-hot, 1-cycle pulse: load data / store ack
resp_rdata  output  DATA_WIDTH  load data, valid when any resp_valid bit is high
mem_read_valid  output  1  memory read request
mem_write_valid  output  1  memory write request
mem_addr  output  ADDR_WIDTH  memory address
mem_wdata  output  DATA_WIDTH  memory write data
mem_ready  input  1  memory accepts the current request
mem_resp_valid  input  1  read data returned
mem_rdata  input  DATA_WIDTH  read data
busy  output  1  high in any state except IDLE

Behaviour:
- Reset (async): state=IDLE, rr_ptr=0. All req_ready, resp_valid, mem_*_valid, busy=0. resp_rdata, mem_addr, mem_wdata=0. Any in-flight transaction is abandoned. A mem_resp_valid arriving later in IDLE is ignored.
- States: IDLE, ISSUE, WAIT_RD, RESPOND.
- IDLE
  - If any req_valid is set, grant the first set bit searching upward from rr_ptr with wrap-around (rr_ptr, rr_ptr+1, ... mod NUM_THREADS).
  - Latch thread id, write flag, address and wdata.
  - Pulse req_ready[granted] for that same cycle (combinational from IDLE + grant). Next state is ISSUE.
  - rr_ptr <= granted+1 mod NUM_THREADS.
  - With no request, stay in IDLE.
- ISSUE
  - Hold mem_read_valid or mem_write_valid (from the latched flag), mem_addr and mem_wdata stable until mem_ready=1.
  - Write + mem_ready: next state RESPOND.
  - Read + mem_ready: next state WAIT_RD.
  - Valid drops in the cycle after mem_ready.
- WAIT_RD
  - Wait indefinitely for mem_resp_valid.
  - Then latch mem_rdata into resp_rdata; next state RESPOND.
- RESPOND
  - resp_valid[latched thread]=1 for exactly one cycle; next state IDLE.
  - Store ack keeps resp_rdata at its previous value.
- Latency: minimum request-to-response is 3 cycles for a write (IDLE, ISSUE with mem_ready=1, RESPOND) and 4 for a read (mem_ready and mem_resp_valid each in their first possible cycle).
- Back-to-back: the next grant occurs in the IDLE cycle following RESPOND, so there is 1 idle cycle between transactions.
- Requesters must hold req_valid/req_write/req_addr/req_wdata until req_ready. req_valid dropped before the grant means no transaction.
- The granted thread may re-request immediately after its resp_valid. Round-robin still gives other pending threads priority.
- mem_resp_valid outside WAIT_RD is ignored. mem_ready outside ISSUE is ignored.
- At most one bit of req_ready and of resp_valid is ever set; never both in the same cycle.
- Arithmetic: only rr_ptr increments, modulo NUM_THREADS with natural wrap.

Test Plan:
- Single load: thread 2 LDR addr 0x10; memory asserts mem_ready on the 1st ISSUE cycle and mem_resp_valid one cycle later with 0xBEEF -> req_ready=0100 once, mem_addr=0x10, resp_valid=0100 for one cycle with resp_rdata=0xBEEF, 4 cycles total.
- Store: thread 1 STR addr 0x3F data 0x1234, mem_ready delayed 3 cycles -> mem_write_valid held 3 cycles with stable addr/data, then resp_valid=0010 one cycle, busy low afterwards.
- Fairness: all four threads request continuously with reset rr_ptr=0 -> grant order 0,1,2,3,0,... and no thread is granted twice before another pending thread.
- Wrap-around: rr_ptr=3, requests from threads 1 and 3 only -> thread 3 granted first, then thread 1.
- Reset mid-read: assert reset in WAIT_RD, release, then drive stale mem_resp_valid=1 -> all outputs 0, no resp_valid pulse, state IDLE.
- Spurious memory signals: mem_resp_valid and mem_ready pulsed while IDLE with no requests -> no output activity, busy=0.

Source files
------------

// File: rtl/data_mem_controller.sv
// Shared load/store front end: round-robin arbitration of per-thread LDR/STR
// requests onto a single valid/ready data memory port, one transaction at a time.
module data_mem_controller #(
  parameter int NUM_THREADS     = 4,
  parameter int THREAD_ID_WIDTH = 2,
  parameter int ADDR_WIDTH      = 8,
  parameter int DATA_WIDTH      = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_THREADS-1:0]            req_valid,
  input  logic [NUM_THREADS-1:0]            req_write,
  input  logic [NUM_THREADS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_THREADS*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_THREADS-1:0]            req_ready,
  output logic [NUM_THREADS-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]             resp_rdata,
  output logic                              mem_read_valid,
  output logic                              mem_write_valid,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic [DATA_WIDTH-1:0]             mem_wdata,
  input  logic                              mem_ready,
  input  logic                              mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]             mem_rdata,
  output logic                              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESPOND} state_t;

  localparam logic [NUM_THREADS-1:0] ONE_HOT_BASE = {{(NUM_THREADS-1){1'b0}}, 1'b1};

  state_t                     state, state_next;
  logic [THREAD_ID_WIDTH-1:0] rr_ptr;
  logic [THREAD_ID_WIDTH-1:0] cur_tid;
  logic                       cur_write;
  logic [ADDR_WIDTH-1:0]      cur_addr;
  logic [DATA_WIDTH-1:0]      cur_wdata;
  logic [THREAD_ID_WIDTH-1:0] grant_id;
  logic [THREAD_ID_WIDTH-1:0] scan_id;
  logic                       grant_found;

  // Search upward from rr_ptr; the index wraps naturally since NUM_THREADS is a power of two.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = rr_ptr;
    scan_id     = rr_ptr;
    for (int i = 0; i < NUM_THREADS; i++) begin
      scan_id = rr_ptr + THREAD_ID_WIDTH'(i);
      if (!grant_found && req_valid[scan_id]) begin
        grant_found = 1'b1;
        grant_id    = scan_id;
      end
    end
  end

  always_comb begin
    state_next      = state;
    req_ready       = '0;
    resp_valid      = '0;
    mem_read_valid  = 1'b0;
    mem_write_valid = 1'b0;
    case (state)
      IDLE: begin
        if (grant_found) begin
          req_ready  = ONE_HOT_BASE << grant_id;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        mem_read_valid  = !cur_write;
        mem_write_valid = cur_write;
        if (mem_ready) state_next = cur_write ? RESPOND : WAIT_RD;
      end
      WAIT_RD: begin
        if (mem_resp_valid) state_next = RESPOND;
      end
      RESPOND: begin
        resp_valid = ONE_HOT_BASE << cur_tid;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_addr  = cur_addr;
  assign mem_wdata = cur_wdata;
  assign busy      = (state != IDLE);

  // Request fields are captured on the grant so requesters are free once req_ready pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      cur_tid    <= '0;
      cur_write  <= 1'b0;
      cur_addr   <= '0;
      cur_wdata  <= '0;
      resp_rdata <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && grant_found) begin
        cur_tid   <= grant_id;
        cur_write <= req_write[grant_id];
        cur_addr  <= req_addr[grant_id*ADDR_WIDTH +: ADDR_WIDTH];
        cur_wdata <= req_wdata[grant_id*DATA_WIDTH +: DATA_WIDTH];
        rr_ptr    <= grant_id + THREAD_ID_WIDTH'(1);
      end
      if (state == WAIT_RD && mem_resp_valid) resp_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_data_mem_controller.sv
// Self-checking bench for data_mem_controller: directed scenarios plus randomized
// traffic checked against a transaction-level round-robin/memory reference model.
module tb_data_mem_controller;

  localparam int NT = 4;
  localparam int TW = 2;
  localparam int AW = 8;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [NT-1:0]     req_valid;
  logic [NT-1:0]     req_write;
  logic [NT*AW-1:0]  req_addr;
  logic [NT*DW-1:0]  req_wdata;
  logic [NT-1:0]     req_ready;
  logic [NT-1:0]     resp_valid;
  logic [DW-1:0]     resp_rdata;
  logic              mem_read_valid;
  logic              mem_write_valid;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic              mem_ready;
  logic              mem_resp_valid;
  logic [DW-1:0]     mem_rdata;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: pending requests, round-robin pointer, transaction in flight.
  logic [NT-1:0] pend;
  logic          p_write [NT];
  logic [AW-1:0] p_addr  [NT];
  logic [DW-1:0] p_wdata [NT];
  int            m_rr;
  bit            m_free, accepted, resp_due;
  int            in_tid;
  logic          in_write;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_wdata;
  logic [DW-1:0] m_last;
  logic [DW-1:0] ref_mem   [256];
  logic [DW-1:0] mem_store [256];
  bit            rd_out;
  logic [AW-1:0] rd_addr_q;
  int            grants_q [$];

  data_mem_controller #(
    .NUM_THREADS(NT), .THREAD_ID_WIDTH(TW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_read_valid(mem_read_valid), .mem_write_valid(mem_write_valid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    mem_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
    pend = '0; m_rr = 0; m_free = 1; accepted = 0; resp_due = 0; m_last = '0;
    rd_out = 0; in_tid = 0; in_write = 0; in_addr = '0; in_wdata = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    if ({req_ready, resp_valid, mem_read_valid, mem_write_valid, busy} !== '0) begin
      n_fail++; $display("[TB] FAIL reset_ctrl: got %b expected 0", {req_ready, resp_valid, mem_read_valid, mem_write_valid, busy});
    end
    n_checks++;
    if ({resp_rdata, mem_addr, mem_wdata} !== '0) begin
      n_fail++; $display("[TB] FAIL reset_data: got %h expected 0", {resp_rdata, mem_addr, mem_wdata});
    end
    n_checks++;
    reset = 1'b0;
  endtask

  task automatic test_single_load();
    do_reset();
    @(negedge clk);
    req_valid = 4'b0100; req_write = 4'b0000; req_addr[2*AW +: AW] = 8'h10;
    #1;
    if (req_ready !== 4'b0100) begin n_fail++; $display("[TB] FAIL load_grant: got %b expected 0100", req_ready); end
    n_checks++;
    @(negedge clk);
    req_valid = '0; mem_ready = 1'b1;
    if ({mem_read_valid, mem_write_valid, mem_addr} !== {2'b10, 8'h10}) begin
      n_fail++; $display("[TB] FAIL load_issue: got %b/%h expected 10/10", {mem_read_valid, mem_write_valid}, mem_addr);
    end
    n_checks++;
    if (req_ready !== '0) begin n_fail++; $display("[TB] FAIL load_ready_once: got %b expected 0000", req_ready); end
    n_checks++;
    @(negedge clk);
    mem_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 16'hBEEF;
    if ({mem_read_valid, resp_valid, busy} !== {1'b0, 4'b0000, 1'b1}) begin
      n_fail++; $display("[TB] FAIL load_wait: got %b expected 000001", {mem_read_valid, resp_valid, busy});
    end
    n_checks++;
    @(negedge clk);
    mem_resp_valid = 1'b0; mem_rdata = 16'h0000;
    if ({resp_valid, resp_rdata} !== {4'b0100, 16'hBEEF}) begin
      n_fail++; $display("[TB] FAIL load_resp: got %b/%h expected 0100/beef", resp_valid, resp_rdata);
    end
    n_checks++;
    @(negedge clk);
    if ({resp_valid, busy} !== 5'b0) begin n_fail++; $display("[TB] FAIL load_done: got %b expected 00000", {resp_valid, busy}); end
    n_checks++;
  endtask

  // Runs directly after test_single_load so the store ack can be seen to hold 0xBEEF.
  task automatic test_store_delayed();
    @(negedge clk);
    req_valid = 4'b0010; req_write = 4'b0010;
    req_addr[1*AW +: AW] = 8'h3F; req_wdata[1*DW +: DW] = 16'h1234;
    #1;
    if (req_ready !== 4'b0010) begin n_fail++; $display("[TB] FAIL store_grant: got %b expected 0010", req_ready); end
    n_checks++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_valid = '0;
      mem_ready = (i == 2);
      if ({mem_write_valid, mem_read_valid, mem_addr, mem_wdata} !== {2'b10, 8'h3F, 16'h1234}) begin
        n_fail++; $display("[TB] FAIL store_hold%0d: got %b/%h/%h expected 10/3f/1234", i, {mem_write_valid, mem_read_valid}, mem_addr, mem_wdata);
      end
      n_checks++;
    end
    @(negedge clk);
    mem_ready = 1'b0;
    if ({resp_valid, mem_write_valid, resp_rdata} !== {4'b0010, 1'b0, 16'hBEEF}) begin
      n_fail++; $display("[TB] FAIL store_ack: got %b/%b/%h expected 0010/0/beef", resp_valid, mem_write_valid, resp_rdata);
    end
    n_checks++;
    @(negedge clk);
    if ({resp_valid, busy} !== 5'b0) begin n_fail++; $display("[TB] FAIL store_idle: got %b expected 00000", {resp_valid, busy}); end
    n_checks++;
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    @(negedge clk);
    req_valid = 4'b0100; req_write = '0; req_addr[2*AW +: AW] = 8'h22;
    @(negedge clk);
    req_valid = '0; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0; reset = 1'b1;
    #1;
    if ({req_ready, resp_valid, mem_read_valid, mem_write_valid, busy, resp_rdata, mem_addr, mem_wdata} !== '0) begin
      n_fail++; $display("[TB] FAIL midread_reset: got %b/%h expected all zero", {req_ready, resp_valid, mem_read_valid, mem_write_valid, busy}, mem_addr);
    end
    n_checks++;
    @(negedge clk);
    reset = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      if ({resp_valid, busy, resp_rdata} !== '0) begin
        n_fail++; $display("[TB] FAIL midread_stale%0d: got %b/%h expected 0/0000", i, {resp_valid, busy}, resp_rdata);
      end
      n_checks++;
    end
    req_valid = 4'b1001;
    #1;
    if (req_ready !== 4'b0001) begin n_fail++; $display("[TB] FAIL midread_rrptr: got %b expected 0001", req_ready); end
    n_checks++;
  endtask

  task automatic test_spurious();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_ready = i[0]; mem_resp_valid = 1'b1; mem_rdata = 16'($urandom);
      #1;
      if ({req_ready, resp_valid, mem_read_valid, mem_write_valid, busy, resp_rdata} !== '0) begin
        n_fail++; $display("[TB] FAIL spurious%0d: got %b/%h expected 0/0000", i, {req_ready, resp_valid, mem_read_valid, mem_write_valid, busy}, resp_rdata);
      end
      n_checks++;
    end
    @(negedge clk);
    mem_ready = 1'b0; mem_resp_valid = 1'b0;
  endtask

  // Random requesters plus a memory with random ready/response delays, compared
  // each cycle with the transaction-level model.
  task automatic run_traffic(input int cycles, input logic [NT-1:0] mask, input int req_pct,
                             input int rdy_pct, input int rsp_pct);
    int cyc;
    bit do_ready, do_resp, found;
    int g;
    logic [NT-1:0] exp_ready, exp_resp;
    bit exp_rd, exp_wr;
    cyc = 0;
    while (cyc < cycles || !m_free || pend != '0) begin
      if (cyc >= cycles + 400) begin
        n_fail++; n_checks++;
        $display("[TB] FAIL drain_timeout: got pending=%b free=%0d expected quiet", pend, m_free);
        break;
      end
      @(negedge clk);
      for (int t = 0; t < NT; t++) begin
        if (!pend[t] && mask[t] && cyc < cycles && $urandom_range(1, 100) <= req_pct) begin
          pend[t] = 1'b1; p_write[t] = 1'($urandom); p_addr[t] = AW'($urandom_range(0, 15)); p_wdata[t] = DW'($urandom);
        end
        req_write[t] = p_write[t];
        req_addr[t*AW +: AW] = p_addr[t];
        req_wdata[t*DW +: DW] = p_wdata[t];
      end
      req_valid = pend;
      exp_rd = !m_free && !accepted && !in_write;
      exp_wr = !m_free && !accepted && in_write;
      if ({mem_read_valid, mem_write_valid} !== {exp_rd, exp_wr}) begin
        n_fail++; $display("[TB] FAIL rnd_memvalid cyc%0d: got %b expected %b", cyc, {mem_read_valid, mem_write_valid}, {exp_rd, exp_wr});
      end
      n_checks++;
      if ((exp_rd || exp_wr) && (mem_addr !== in_addr || (exp_wr && mem_wdata !== in_wdata))) begin
        n_fail++; $display("[TB] FAIL rnd_memaddr cyc%0d: got %h/%h expected %h/%h", cyc, mem_addr, mem_wdata, in_addr, in_wdata);
      end
      if (exp_rd || exp_wr) n_checks++;
      do_ready = 0; do_resp = 0;
      if (rd_out) begin
        if ($urandom_range(1, 100) <= rsp_pct) begin do_resp = 1; rd_out = 0; end
      end else if (mem_read_valid || mem_write_valid) begin
        if ($urandom_range(1, 100) <= rdy_pct) begin
          do_ready = 1;
          if (mem_write_valid) mem_store[mem_addr] = mem_wdata;
          else begin rd_out = 1; rd_addr_q = mem_addr; end
        end
      end else begin
        do_ready = ($urandom_range(0, 9) == 0);
        do_resp  = ($urandom_range(0, 9) == 0);
      end
      mem_ready = do_ready; mem_resp_valid = do_resp;
      mem_rdata = (do_resp && !rd_out && !(mem_read_valid || mem_write_valid)) ? mem_store[rd_addr_q] : DW'($urandom);
      #1;
      exp_ready = '0; found = 0; g = 0;
      if (m_free) begin
        for (int k = 0; k < NT; k++) begin
          if (!found && pend[(m_rr + k) % NT]) begin found = 1; g = (m_rr + k) % NT; end
        end
        if (found) exp_ready[g] = 1'b1;
      end
      exp_resp = '0;
      if (resp_due) exp_resp[in_tid] = 1'b1;
      if (req_ready !== exp_ready) begin n_fail++; $display("[TB] FAIL rnd_req_ready cyc%0d: got %b expected %b", cyc, req_ready, exp_ready); end
      n_checks++;
      if (resp_valid !== exp_resp) begin n_fail++; $display("[TB] FAIL rnd_resp_valid cyc%0d: got %b expected %b", cyc, resp_valid, exp_resp); end
      n_checks++;
      if (resp_rdata !== m_last) begin n_fail++; $display("[TB] FAIL rnd_resp_rdata cyc%0d: got %h expected %h", cyc, resp_rdata, m_last); end
      n_checks++;
      if (busy !== !m_free) begin n_fail++; $display("[TB] FAIL rnd_busy cyc%0d: got %b expected %b", cyc, busy, !m_free); end
      n_checks++;
      if (m_free) begin
        if (found) begin
          m_free = 0; accepted = 0; in_tid = g; in_write = p_write[g]; in_addr = p_addr[g]; in_wdata = p_wdata[g];
          pend[g] = 1'b0; m_rr = (g + 1) % NT; grants_q.push_back(g);
        end
      end else if (resp_due) begin
        resp_due = 0; m_free = 1;
      end else if (!accepted && do_ready) begin
        accepted = 1;
        if (in_write) begin ref_mem[in_addr] = in_wdata; resp_due = 1; end
      end else if (accepted && !in_write && do_resp) begin
        resp_due = 1; m_last = ref_mem[in_addr];
      end
      cyc++;
    end
    @(negedge clk);
    mem_ready = 1'b0; mem_resp_valid = 1'b0; req_valid = '0;
  endtask

  task automatic test_fairness();
    do_reset();
    grants_q.delete();
    run_traffic(60, 4'b1111, 100, 70, 70);
    if (grants_q.size() < 8) begin n_fail++; $display("[TB] FAIL fair_count: got %0d expected >=8", grants_q.size()); end
    n_checks++;
    for (int i = 0; i < 8 && i < grants_q.size(); i++) begin
      if (grants_q[i] != i % NT) begin n_fail++; $display("[TB] FAIL fair_order%0d: got %0d expected %0d", i, grants_q[i], i % NT); end
      n_checks++;
    end
  endtask

  task automatic test_wrap();
    do_reset();
    run_traffic(1, 4'b0100, 100, 100, 100);
    grants_q.delete();
    run_traffic(1, 4'b1010, 100, 50, 50);
    if (grants_q.size() != 2) begin n_fail++; $display("[TB] FAIL wrap_count: got %0d expected 2", grants_q.size()); end
    else begin
      if (grants_q[0] != 3 || grants_q[1] != 1) begin
        n_fail++; $display("[TB] FAIL wrap_order: got %0d,%0d expected 3,1", grants_q[0], grants_q[1]);
      end
    end
    n_checks++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_traffic(500, 4'b1111, 30, 60, 60);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = DW'($urandom);
      mem_store[i] = ref_mem[i];
    end
    reset = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    mem_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
    test_reset();
    test_single_load();
    test_store_delayed();
    test_reset_mid_read();
    test_spurious();
    test_fairness();
    test_wrap();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
